// File: rtl/fetch_pc_ctrl_if.sv
// Fetch request/acknowledge channel plus the queue-push strobe that the
// fetch PC controller drives toward memory and the instruction queue.
interface fetch_pc_ctrl_if #(
  parameter int unsigned ADDR_W = 64
) ();
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic              push;
  logic [ADDR_W-1:0] push_addr;

  modport master (
    output fetch_req,
    output fetch_addr,
    output push,
    output push_addr,
    input  fetch_ack
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    input  push,
    input  push_addr,
    output fetch_ack
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: picks the next fetch block address from boot, redirect and
// sequential sources, keeps the req/ack handshake stable, and drops wrong-path data.
module fetch_pc_ctrl #(
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned ADDR_W          = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] boot_addr_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              fb_mispred_i,
  input  logic [ADDR_W-1:0] fb_target_i,
  input  logic              bp_taken_i,
  input  logic [ADDR_W-1:0] bp_target_i,
  input  logic              halt_i,
  input  logic              q_afull_i,
  fetch_pc_ctrl_if.master   fetch,
  output logic [1:0]        state_o
);

  localparam int unsigned     BLK_BYTES = 4 * INSTR_PER_FETCH;
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(BLK_BYTES - 1);
  localparam logic [ADDR_W-1:0] BLK_SIZE = ADDR_W'(BLK_BYTES);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e            state_q, state_next;
  logic [ADDR_W-1:0] pc_q, pc_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [ADDR_W-1:0] tgt_q, tgt_next;
  logic              req_q, req_next;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              can_issue;
  logic              issue;
  logic              ack;

  // Next block address: align down to the block, then step one block (wraps at top).
  function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] a);
    return (a & ~BLK_MASK) + BLK_SIZE;
  endfunction

  always_comb begin
    redirect     = 1'b0;
    redirect_tgt = '0;
    if (state_q != ST_BOOT) begin
      if (flush_i) begin
        redirect     = 1'b1;
        redirect_tgt = flush_pc_i;
      end else if (fb_mispred_i) begin
        redirect     = 1'b1;
        redirect_tgt = fb_target_i;
      end else if (bp_taken_i && state_q == ST_FETCH) begin
        redirect     = 1'b1;
        redirect_tgt = bp_target_i;
      end
    end
  end

  always_comb begin
    ack        = fetch.fetch_ack;
    can_issue  = !halt_i && !q_afull_i;
    state_next = state_q;
    pc_next    = pc_q;
    tgt_next   = tgt_q;
    req_next   = req_q;
    addr_next  = addr_q;
    issue      = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        pc_next    = boot_addr_i;
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect && req_q && !ack) begin
          // The outstanding request cannot be withdrawn; park until it returns.
          state_next = ST_DISCARD;
          tgt_next   = redirect_tgt;
        end else begin
          if (redirect) begin
            pc_next = redirect_tgt;
          end else if (ack) begin
            pc_next = seq_pc(pc_q);
          end
          issue = (!req_q || ack) && can_issue;
        end
      end
      ST_DISCARD: begin
        if (ack) begin
          pc_next    = redirect ? redirect_tgt : tgt_q;
          state_next = ST_FETCH;
          issue      = can_issue;
        end else if (redirect) begin
          tgt_next = redirect_tgt;
        end
      end
      default: state_next = ST_BOOT;
    endcase

    // A newly issued request always targets the PC being installed this cycle.
    if (issue) begin
      req_next  = 1'b1;
      addr_next = pc_next;
    end else if (ack) begin
      req_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
      addr_q  <= '0;
      tgt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_next;
      pc_q    <= pc_next;
      addr_q  <= addr_next;
      tgt_q   <= tgt_next;
      req_q   <= req_next;
    end
  end

  assign fetch.fetch_req  = req_q;
  assign fetch.fetch_addr = addr_q;
  assign fetch.push       = ack && (state_q == ST_FETCH) && !redirect;
  assign fetch.push_addr  = addr_q;
  assign state_o          = state_q;

`ifndef SYNTHESIS
  ack_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni) fetch.fetch_ack |-> req_q);
`endif

endmodule
